// File: rtl/gpi_edge_irq.sv
// Avalon-MM general-purpose input port with synchronizer, sticky edge capture and maskable level IRQ.
// Optional per-bit debounce filter enabled by defining GPI_DEBOUNCE_EN.
module gpi_edge_irq #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

`ifdef GPI_DEBOUNCE_EN
  localparam int ARM = 3 + DEBOUNCE_CYCLES;
`else
  localparam int ARM = 3;
`endif
  localparam int ARM_W = $clog2(ARM + 1);

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [WIDTH-1:0] r_prev_p2;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [31:0]      w_rd_mux;
  logic             w_armed;
  logic             w_wr;

  // Two-flop synchronizer for the asynchronous board inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= in_port;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef GPI_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_deb_cnt [WIDTH];

  // A bit is accepted only after it has differed from the debounced value for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= '0;
      for (int i = 0; i < WIDTH; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync_p1[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i]     <= r_sync_p1[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_filt = r_deb;
`else
  assign w_filt = r_sync_p1;
`endif

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_filt & ~r_prev_p2;
      1:       w_edge = ~w_filt & r_prev_p2;
      default: w_edge = w_filt ^ r_prev_p2;
    endcase
  end

  assign w_armed = (r_arm_cnt == ARM_W'(ARM));
  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_clr   = (w_wr && (address == 3'd3)) ? w_wdata : '0;

  always_comb begin
    w_mask_nxt = r_irq_mask;
    if (w_wr) begin
      case (address)
        3'd2:    w_mask_nxt = w_wdata;
        3'd4:    w_mask_nxt = r_irq_mask | w_wdata;
        3'd5:    w_mask_nxt = r_irq_mask & ~w_wdata;
        default: w_mask_nxt = r_irq_mask;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0:    w_rd_mux[WIDTH-1:0] = w_filt;
      3'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
      3'd3:    w_rd_mux[WIDTH-1:0] = r_edge_cap;
      default: w_rd_mux = '0;
    endcase
  end

  // Edge capture, mask, IRQ and read-data registers; a new edge wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_p2  <= '0;
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      r_arm_cnt  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (!w_armed) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      r_prev_p2  <= w_filt;
      r_edge_cap <= (r_edge_cap & ~w_clr) | (w_edge & {WIDTH{w_armed}});
      r_irq_mask <= w_mask_nxt;
      r_irq      <= |(r_edge_cap & r_irq_mask);
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_gpi_edge_irq.sv
// Bench for gpi_edge_irq: rising-edge and any-edge instances side by side, history-based model
// plus directed vectors with literal expectations.
module tb_gpi_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = 8'hFF;
  logic [31:0] rd_rise, rd_any;
  logic        irq_rise, irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpi_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
    .in_port(in_port), .irq(irq_rise));

  gpi_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_port), .irq(irq_any));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] er, input logic [31:0] ea, input string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    step();
    chk({nm, "_rise"}, rd_rise, er);
    chk({nm, "_any"}, rd_any, ea);
    chipselect = 1'b0;
  endtask

  // Model: input history per clock edge; the filtered value seen before edge n+1 is the
  // input sampled two edges earlier. Index 0 = rising instance, 1 = any-edge instance.
  logic [7:0]  hist[$];
  int          mn = 0;
  logic [7:0]  m_cap [2];
  logic [7:0]  m_mask = '0;
  logic        m_irq [2];
  logic [31:0] m_rd [2];
  logic [7:0]  mf, mp, mwd, mclr;
  logic [7:0]  mev [2];
  logic        marmed;

  function automatic logic [7:0] h_at(input int j);
    if (j >= 1 && j <= hist.size()) return hist[j-1];
    return 8'h00;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cap[i] = '0; m_irq[i] = 1'b0; m_rd[i] = '0;
    end
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        hist.delete();
        mn = 0;
        m_mask = '0;
        for (int i = 0; i < 2; i++) begin
          m_cap[i] = '0; m_irq[i] = 1'b0; m_rd[i] = '0;
        end
      end else begin
        mf     = h_at(mn - 1);
        mp     = h_at(mn - 2);
        mev[0] = mf & ~mp;
        mev[1] = mf ^ mp;
        marmed = (mn >= 3);
        mwd    = writedata[7:0];
        mclr   = (chipselect && !write_n && address == 3'd3) ? mwd : 8'h00;
        for (int i = 0; i < 2; i++) begin
          m_irq[i] = |(m_cap[i] & m_mask);
          case (address)
            3'd0:    m_rd[i] = {24'h0, mf};
            3'd2:    m_rd[i] = {24'h0, m_mask};
            3'd3:    m_rd[i] = {24'h0, m_cap[i]};
            default: m_rd[i] = 32'h0;
          endcase
          m_cap[i] = (m_cap[i] & ~mclr) | (marmed ? mev[i] : 8'h00);
        end
        if (chipselect && !write_n) begin
          if (address == 3'd2) m_mask = mwd;
          else if (address == 3'd4) m_mask = m_mask | mwd;
          else if (address == 3'd5) m_mask = m_mask & ~mwd;
        end
        hist.push_back(in_port);
        mn++;
      end
    end
  end

`ifndef GPI_DEBOUNCE_EN
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("cyc_rd_rise_rst", rd_rise, 32'h0);
      chk("cyc_rd_any_rst", rd_any, 32'h0);
      chk("cyc_irq_rise_rst", {31'h0, irq_rise}, 32'h0);
      chk("cyc_irq_any_rst", {31'h0, irq_any}, 32'h0);
    end else begin
      chk("cyc_rd_rise", rd_rise, m_rd[0]);
      chk("cyc_rd_any", rd_any, m_rd[1]);
      chk("cyc_irq_rise", {31'h0, irq_rise}, {31'h0, m_irq[0]});
      chk("cyc_irq_any", {31'h0, irq_any}, {31'h0, m_irq[1]});
    end
  end
`endif

  initial begin
    repeat (3) step();
    chk("rst_rd", rd_rise, 32'h0);
    chk("rst_irq", {31'h0, irq_rise}, 32'h0);
    reset_n = 1'b1;
    repeat (10) step();
`ifndef GPI_DEBOUNCE_EN
    rd(3'd3, 32'h00, 32'h00, "t1_cap");
    chk("t1_irq", {30'h0, irq_rise, irq_any}, 32'h0);
    rd(3'd0, 32'hFF, 32'hFF, "t1_data");

    in_port = 8'h00;
    repeat (6) step();
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h04);
    rd(3'd3, 32'h00, 32'h00, "prep_cap");

    in_port = 8'h04;
    repeat (3) step();
    chk("t2_irq_early", {31'h0, irq_rise}, 32'h0);
    step();
    chk("t2_irq_set", {30'h0, irq_rise, irq_any}, 32'h3);
    rd(3'd3, 32'h04, 32'h04, "t2_cap");
    wr(3'd3, 32'h04);
    chk("t2_irq_hold", {31'h0, irq_rise}, 32'h1);
    step();
    chk("t2_irq_clr", {30'h0, irq_rise, irq_any}, 32'h0);

    wr(3'd2, 32'h00);
    wr(3'd4, 32'h30);
    wr(3'd5, 32'h10);
    rd(3'd2, 32'h20, 32'h20, "t3_mask");
    rd(3'd4, 32'h00, 32'h00, "t3_set_rd");
    rd(3'd5, 32'h00, 32'h00, "t3_clr_rd");
    wr(3'd4, 32'hFFFF_FF00);
    rd(3'd2, 32'h20, 32'h20, "t3_hi_ignored");
    wr(3'd1, 32'hFF);
    rd(3'd1, 32'h00, 32'h00, "t3_addr1");
    rd(3'd6, 32'h00, 32'h00, "t3_addr6");

    in_port = 8'h05;
    repeat (3) step();
    in_port = 8'h04;
    step();
    in_port = 8'h05;
    repeat (2) step();
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h01, 32'h01, "t4_set_wins");
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h00, 32'h00, "t4_w1c");

    wr(3'd2, 32'h00);
    in_port = 8'h85;
    repeat (5) step();
    wr(3'd3, 32'hFF);
    in_port = 8'h05;
    repeat (5) step();
    rd(3'd3, 32'h00, 32'h80, "t5_cap");
    chk("t5_irq_masked", {30'h0, irq_rise, irq_any}, 32'h0);
    wr(3'd2, 32'h80);
    chk("t5_irq_lag", {31'h0, irq_any}, 32'h0);
    step();
    chk("t5_irq_unmasked", {30'h0, irq_rise, irq_any}, 32'h1);
    wr(3'd5, 32'h80);
    step();
    chk("t5_irq_off", {31'h0, irq_any}, 32'h0);

    rd(3'd0, 32'h05, 32'h05, "t7_pre_data");
    reset_n = 1'b0;
    #1;
    chk("t7_rst_rd", rd_any, 32'h0);
    chk("t7_rst_irq", {30'h0, irq_rise, irq_any}, 32'h0);
    in_port = 8'hFF;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (10) step();
    rd(3'd3, 32'h00, 32'h00, "t7_cap");
    rd(3'd0, 32'hFF, 32'hFF, "t7_data");
    chk("t7_irq", {30'h0, irq_rise, irq_any}, 32'h0);
`else
    repeat (20) step();
    rd(3'd3, 32'h00, 32'h00, "t6_arm_cap");
    rd(3'd0, 32'hFF, 32'hFF, "t6_arm_data");
    in_port = 8'h00;
    repeat (30) step();
    wr(3'd3, 32'hFF);
    rd(3'd0, 32'h00, 32'h00, "t6_low_data");
    in_port = 8'h02;
    repeat (10) step();
    in_port = 8'h00;
    repeat (30) step();
    rd(3'd0, 32'h00, 32'h00, "t6_glitch_data");
    rd(3'd3, 32'h00, 32'h00, "t6_glitch_cap");
    in_port = 8'h02;
    repeat (20) step();
    rd(3'd3, 32'h02, 32'h02, "t6_stable_cap");
    rd(3'd0, 32'h02, 32'h02, "t6_stable_data");
    chk("t6_irq", {30'h0, irq_rise, irq_any}, 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
